// File: rtl/ddr2_arbit_if.sv
// Sequencer-side and pin-side signal bundle for the DDR2 command arbiter.
// BA_BITS / ADDR_BITS fall back to 2 / 13 when the controller does not define them.
`ifndef BA_BITS
`define BA_BITS 2
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 13
`endif

interface ddr2_arbit_if #(
    parameter int BA_W   = `BA_BITS,
    parameter int ADDR_W = `ADDR_BITS
);
    logic              init_end;
    logic [3:0]        init_cmd;
    logic [BA_W-1:0]   init_ba;
    logic [ADDR_W-1:0] init_addr;

    logic              aref_req;
    logic              aref_en;
    logic [3:0]        aref_cmd;
    logic [ADDR_W-1:0] aref_addr;
    logic              aref_end;

    logic              wr_req;
    logic              wr_en;
    logic [3:0]        wr_cmd;
    logic [BA_W-1:0]   wr_ba;
    logic [ADDR_W-1:0] wr_addr;
    logic              wr_end;

    logic              rd_req;
    logic              rd_en;
    logic [3:0]        rd_cmd;
    logic [BA_W-1:0]   rd_ba;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_end;

    logic [3:0]        ddr_cmd;
    logic [BA_W-1:0]   ddr_ba;
    logic [ADDR_W-1:0] ddr_addr;
    logic              arb_err;

    // Handshake: *_req is a level held until its *_en pulse; *_en is high for exactly
    // the first cycle of the grant; *_end (a level of 1-2 cycles) closes the grant.
    modport master (
        output init_end, init_cmd, init_ba, init_addr,
        output aref_req, aref_cmd, aref_addr, aref_end,
        output wr_req, wr_cmd, wr_ba, wr_addr, wr_end,
        output rd_req, rd_cmd, rd_ba, rd_addr, rd_end,
        input  aref_en, wr_en, rd_en,
        input  ddr_cmd, ddr_ba, ddr_addr, arb_err
    );

    modport slave (
        input  init_end, init_cmd, init_ba, init_addr,
        input  aref_req, aref_cmd, aref_addr, aref_end,
        input  wr_req, wr_cmd, wr_ba, wr_addr, wr_end,
        input  rd_req, rd_cmd, rd_ba, rd_addr, rd_end,
        output aref_en, wr_en, rd_en,
        output ddr_cmd, ddr_ba, ddr_addr, arb_err
    );
endinterface

// File: rtl/ddr2_arbit.sv
// DDR2 command arbiter: grants init/refresh/write/read sequencers and registers the pins.
// Define ARB_RR_EN to alternate contested write/read grants; otherwise write beats read.
`ifndef BA_BITS
`define BA_BITS 2
`endif
`ifndef ADDR_BITS
`define ADDR_BITS 13
`endif

module ddr2_arbit #(
    parameter int BA_W    = `BA_BITS,
    parameter int ADDR_W  = `ADDR_BITS,
    parameter int TMO_CYC = 1023
) (
    input  logic              ck,
    input  logic              rst_n,
    ddr2_arbit_if.slave       bus,
    output logic [2:0]        state_dbg
);
    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_AREF  = 3'd2,
        ST_WRITE = 3'd3,
        ST_READ  = 3'd4
    } state_t;

    localparam int CNT_W = ($clog2(TMO_CYC + 1) > 10) ? $clog2(TMO_CYC + 1) : 10;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO_CYC - 1);
    localparam logic [3:0]       CMD_NOP  = 4'b0111;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              aref_en_q, aref_en_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [3:0]        cmd_q, cmd_d;
    logic [BA_W-1:0]   ba_q, ba_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              tmo;
    logic              wr_pick;

`ifdef ARB_RR_EN
    logic last_wr_q, last_wr_d;

    // Contested write/read goes to whichever did not win the last data grant.
    assign wr_pick = bus.wr_req && !(bus.rd_req && last_wr_q);

    always_comb begin
        last_wr_d = last_wr_q;
        if (wr_en_d) begin
            last_wr_d = 1'b1;
        end else if (rd_en_d) begin
            last_wr_d = 1'b0;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            last_wr_q <= 1'b0;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end
`else
    assign wr_pick = bus.wr_req;
`endif

    // The counter holds the number of cycles already spent in the current grant.
    assign tmo = (cnt_q == TMO_LAST);

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        err_d   = err_q;
        case (state_q)
            ST_INIT: begin
                if (bus.init_end) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (bus.aref_req)    state_d = ST_AREF;
                else if (wr_pick)    state_d = ST_WRITE;
                else if (bus.rd_req) state_d = ST_READ;
            end
            ST_AREF: begin
                if (bus.aref_end) begin
                    state_d = ST_IDLE;
                end else if (tmo) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WRITE: begin
                if (bus.wr_end) begin
                    state_d = ST_IDLE;
                end else if (tmo) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_READ: begin
                if (bus.rd_end) begin
                    state_d = ST_IDLE;
                end else if (tmo) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_INIT;
        endcase
        aref_en_d = (state_q == ST_IDLE) && (state_d == ST_AREF);
        wr_en_d   = (state_q == ST_IDLE) && (state_d == ST_WRITE);
        rd_en_d   = (state_q == ST_IDLE) && (state_d == ST_READ);
    end

    always_comb begin
        cmd_d  = CMD_NOP;
        ba_d   = '0;
        addr_d = '0;
        case (state_q)
            ST_INIT: begin
                cmd_d  = bus.init_cmd;
                ba_d   = bus.init_ba;
                addr_d = bus.init_addr;
            end
            ST_AREF: begin
                cmd_d  = bus.aref_cmd;
                addr_d = bus.aref_addr;
            end
            ST_WRITE: begin
                cmd_d  = bus.wr_cmd;
                ba_d   = bus.wr_ba;
                addr_d = bus.wr_addr;
            end
            ST_READ: begin
                cmd_d  = bus.rd_cmd;
                ba_d   = bus.rd_ba;
                addr_d = bus.rd_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_INIT;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            cmd_q     <= CMD_NOP;
            ba_q      <= '0;
            addr_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            aref_en_q <= aref_en_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            cmd_q     <= cmd_d;
            ba_q      <= ba_d;
            addr_q    <= addr_d;
        end
    end

    assign bus.aref_en  = aref_en_q;
    assign bus.wr_en    = wr_en_q;
    assign bus.rd_en    = rd_en_q;
    assign bus.ddr_cmd  = cmd_q;
    assign bus.ddr_ba   = ba_q;
    assign bus.ddr_addr = addr_q;
    assign bus.arb_err  = err_q;
    assign state_dbg    = state_q;
endmodule
